// File: rtl/dcache_dirt_ctrl.sv
// Miss/eviction sequencer for the dcache per-set dirty-bit register file.
// Define DCACHE_FLUSH_EN to add the full-cache flush sweep (flush_req / flush_done).
module dcache_dirt_ctrl #(
  parameter int GROUP_NUM   = 128,
  parameter int INDEX_WIDTH = $clog2(GROUP_NUM)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   miss_valid,
  output logic                   miss_ready,
  input  logic [INDEX_WIDTH-1:0] miss_index,
  input  logic                   miss_store,
  output logic                   miss_done,
  output logic                   set_D,
  output logic                   wdirt,
  output logic [INDEX_WIDTH-1:0] addra,
  output logic [INDEX_WIDTH-1:0] addrb,
  input  logic                   isDirt,
  output logic                   wb_valid,
  input  logic                   wb_ready,
  output logic [INDEX_WIDTH-1:0] wb_index,
  input  logic                   wb_done,
  output logic                   rf_valid,
  input  logic                   rf_ready,
  output logic [INDEX_WIDTH-1:0] rf_index,
  input  logic                   rf_done,
`ifdef DCACHE_FLUSH_EN
  input  logic                   flush_req,
  output logic                   flush_done,
`endif
  output logic                   busy
);

  typedef enum logic [3:0] {
    IDLE, LOOKUP, CHECK, WB_REQ, WB_WAIT, RF_REQ, RF_WAIT, UPDATE
`ifdef DCACHE_FLUSH_EN
    , FL_LOOKUP, FL_CHECK, FL_WB_REQ, FL_WB_WAIT, FL_CLEAR
`endif
  } state_t;

  state_t                 state_q, state_d;
  logic [INDEX_WIDTH-1:0] idx_q, idx_d;
  logic                   st_q, st_d;
`ifdef DCACHE_FLUSH_EN
  logic [INDEX_WIDTH-1:0] cnt_q, cnt_d;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      idx_q   <= '0;
      st_q    <= 1'b0;
`ifdef DCACHE_FLUSH_EN
      cnt_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      st_q    <= st_d;
`ifdef DCACHE_FLUSH_EN
      cnt_q   <= cnt_d;
`endif
    end
  end

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    st_d       = st_q;
    miss_ready = 1'b0;
    miss_done  = 1'b0;
    set_D      = 1'b0;
    wdirt      = 1'b0;
    addra      = idx_q;
    addrb      = idx_q;
    wb_valid   = 1'b0;
    wb_index   = idx_q;
    rf_valid   = 1'b0;
    rf_index   = idx_q;
`ifdef DCACHE_FLUSH_EN
    cnt_d      = cnt_q;
    flush_done = 1'b0;
`endif

    case (state_q)
      IDLE: begin
        // Held low while reset is asserted so every output reads 0 during reset.
        miss_ready = !reset;
`ifdef DCACHE_FLUSH_EN
        if (flush_req) begin
          miss_ready = 1'b0;
          state_d    = FL_LOOKUP;
        end else
`endif
        if (miss_valid) begin
          idx_d   = miss_index;
          st_d    = miss_store;
          state_d = LOOKUP;
        end
      end
      LOOKUP: state_d = CHECK;
      CHECK:  state_d = isDirt ? WB_REQ : RF_REQ;
      WB_REQ: begin
        wb_valid = 1'b1;
        if (wb_ready) state_d = WB_WAIT;
      end
      WB_WAIT: if (wb_done) state_d = RF_REQ;
      RF_REQ: begin
        rf_valid = 1'b1;
        if (rf_ready) state_d = RF_WAIT;
      end
      RF_WAIT: if (rf_done) state_d = UPDATE;
      UPDATE: begin
        set_D     = 1'b1;
        wdirt     = st_q;
        miss_done = 1'b1;
        state_d   = IDLE;
      end
`ifdef DCACHE_FLUSH_EN
      FL_LOOKUP: begin
        addrb   = cnt_q;
        state_d = FL_CHECK;
      end
      FL_CHECK: state_d = isDirt ? FL_WB_REQ : FL_CLEAR;
      FL_WB_REQ: begin
        wb_valid = 1'b1;
        wb_index = cnt_q;
        if (wb_ready) state_d = FL_WB_WAIT;
      end
      FL_WB_WAIT: if (wb_done) state_d = FL_CLEAR;
      FL_CLEAR: begin
        set_D = 1'b1;
        addra = cnt_q;
        cnt_d = cnt_q + INDEX_WIDTH'(1);
        if (cnt_q == INDEX_WIDTH'(GROUP_NUM - 1)) begin
          flush_done = 1'b1;
          state_d    = IDLE;
        end else begin
          state_d = FL_LOOKUP;
        end
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  assign busy = (state_q != IDLE);

endmodule

// File: tb/tb_dcache_dirt_ctrl.sv
// Directed self-checking bench for dcache_dirt_ctrl with a behavioural dirty-bit file.
// Flush sweep is exercised (GROUP_NUM=8) when DCACHE_FLUSH_EN is defined.
module tb_dcache_dirt_ctrl;
`ifdef DCACHE_FLUSH_EN
  localparam int G = 8;
`else
  localparam int G = 128;
`endif
  localparam int IW = $clog2(G);
  localparam logic [IW-1:0] IDX_A = IW'(5 % G);
  localparam logic [IW-1:0] IDX_B = IW'(9 % G);
  localparam logic [IW-1:0] IDX_C = IW'(12 % G);
  localparam logic [IW-1:0] IDX_D = IW'(33 % G);
  localparam logic [IW-1:0] IDX_E = IW'(40 % G);
  localparam logic [IW-1:0] IDX_X = IW'(21 % G);

  logic clk = 1'b0;
  logic reset, miss_valid, miss_ready, miss_store, miss_done;
  logic set_D, wdirt, isDirt;
  logic [IW-1:0] miss_index, addra, addrb, wb_index, rf_index;
  logic wb_valid, wb_ready, wb_done, rf_valid, rf_ready, rf_done, busy;
`ifdef DCACHE_FLUSH_EN
  logic flush_req, flush_done;
  int   n_flush_done = 0;
`endif

  int checks = 0;
  int failures = 0;
  int n_miss_done = 0;

  logic mem [G];
  logic rd_q;

  always #5 clk = ~clk;

  dcache_dirt_ctrl #(.GROUP_NUM(G)) dut (
    .clk(clk), .reset(reset),
    .miss_valid(miss_valid), .miss_ready(miss_ready), .miss_index(miss_index),
    .miss_store(miss_store), .miss_done(miss_done),
    .set_D(set_D), .wdirt(wdirt), .addra(addra), .addrb(addrb), .isDirt(isDirt),
    .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_index(wb_index), .wb_done(wb_done),
    .rf_valid(rf_valid), .rf_ready(rf_ready), .rf_index(rf_index), .rf_done(rf_done),
`ifdef DCACHE_FLUSH_EN
    .flush_req(flush_req), .flush_done(flush_done),
`endif
    .busy(busy)
  );

  // Dirty-bit file: one write port, one-cycle synchronous read port.
  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < G; i++) mem[i] <= 1'b0;
    end else if (set_D) begin
      mem[addra] <= wdirt;
    end
    rd_q <= reset ? 1'b0 : mem[addrb];
  end
  assign isDirt = rd_q;

  always @(posedge clk) begin
    if (!reset) begin
      if (miss_done) n_miss_done++;
`ifdef DCACHE_FLUSH_EN
      if (flush_done) n_flush_done++;
`endif
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One complete miss with ready bus and immediate done pulses.
  task automatic do_miss(input logic [IW-1:0] index, input logic store, input logic dirty,
                         input string tag);
    miss_valid = 1'b1; miss_index = index; miss_store = store;
    step();
    miss_valid = 1'b0; miss_store = 1'b0;
    check({tag, ".lookup_addrb"}, addrb, index);
    check({tag, ".lookup_ready"}, miss_ready, 1'b0);
    step();
    check({tag, ".check_wb"}, wb_valid, 1'b0);
    check({tag, ".check_rf"}, rf_valid, 1'b0);
    if (dirty) begin
      step();
      check({tag, ".wb_valid"}, wb_valid, 1'b1);
      check({tag, ".wb_index"}, wb_index, index);
      check({tag, ".wb_rf_low"}, rf_valid, 1'b0);
      step();
      check({tag, ".wbwait_valid"}, wb_valid, 1'b0);
      wb_done = 1'b1;
      step();
      wb_done = 1'b0;
    end else begin
      step();
    end
    check({tag, ".rf_valid"}, rf_valid, 1'b1);
    check({tag, ".rf_index"}, rf_index, index);
    check({tag, ".rf_wb_low"}, wb_valid, 1'b0);
    step();
    check({tag, ".rfwait_valid"}, rf_valid, 1'b0);
    rf_done = 1'b1;
    step();
    rf_done = 1'b0;
    check({tag, ".set_D"}, set_D, 1'b1);
    check({tag, ".addra"}, addra, index);
    check({tag, ".wdirt"}, wdirt, store);
    check({tag, ".miss_done"}, miss_done, 1'b1);
    step();
    check({tag, ".done_pulse"}, miss_done, 1'b0);
    check({tag, ".ready_again"}, miss_ready, 1'b1);
  endtask

  initial begin
    logic [IW-1:0] wb_log[$];
    int exp_clr, fl_cycles;
    logic prev_wb, done_seen, all_clear;
    reset = 1'b1; miss_valid = 1'b0; miss_index = '0; miss_store = 1'b0;
    wb_ready = 1'b1; wb_done = 1'b0; rf_ready = 1'b1; rf_done = 1'b0;
`ifdef DCACHE_FLUSH_EN
    flush_req = 1'b0;
`endif

    // Reset state
    step(); step();
    check("rst.miss_ready", miss_ready, 1'b0);
    check("rst.busy", busy, 1'b0);
    check("rst.set_D", set_D, 1'b0);
    check("rst.miss_done", miss_done, 1'b0);
    check("rst.wb_valid", wb_valid, 1'b0);
    check("rst.rf_valid", rf_valid, 1'b0);
    check("rst.addrb", addrb, '0);
    check("rst.addra", addra, '0);
    reset = 1'b0;
    step();
    check("post_rst.miss_ready", miss_ready, 1'b1);

    // Clean load miss, then store miss followed by load miss on the same set
    do_miss(IDX_A, 1'b0, 1'b0, "clean");
    do_miss(IDX_B, 1'b1, 1'b0, "store");
    check("store.file_bit", mem[IDX_B], 1'b1);
    do_miss(IDX_B, 1'b0, 1'b1, "dirty");
    check("dirty.file_bit", mem[IDX_B], 1'b0);

    // Write-back stall with a competing miss request
    do_miss(IDX_C, 1'b1, 1'b0, "stall_setup");
    wb_ready = 1'b0;
    miss_valid = 1'b1; miss_index = IDX_C;
    step();
    miss_valid = 1'b0;
    step(); step();
    check("stall.wb_valid0", wb_valid, 1'b1);
    miss_valid = 1'b1; miss_index = IDX_X;
    for (int i = 0; i < 10; i++) begin
      step();
      check("stall.wb_valid", wb_valid, 1'b1);
      check("stall.wb_index", wb_index, IDX_C);
      check("stall.rf_valid", rf_valid, 1'b0);
      check("stall.miss_ready", miss_ready, 1'b0);
    end
    miss_valid = 1'b0; wb_ready = 1'b1;
    step();
    check("stall.wbwait", wb_valid, 1'b0);
    wb_done = 1'b1;
    step();
    wb_done = 1'b0;
    check("stall.rf_index", rf_index, IDX_C);
    step();
    rf_done = 1'b1;
    step();
    rf_done = 1'b0;
    check("stall.addra", addra, IDX_C);
    check("stall.wdirt", wdirt, 1'b0);
    check("stall.set_D", set_D, 1'b1);
    step();
    check("stall.idle", busy, 1'b0);

    // Reset during RF_WAIT aborts the miss
    miss_valid = 1'b1; miss_index = IDX_D; miss_store = 1'b1;
    step();
    miss_valid = 1'b0; miss_store = 1'b0;
    step(); step(); step();
    check("abort.in_rfwait", busy, 1'b1);
    reset = 1'b1; rf_done = 1'b1;
    step();
    check("abort.busy", busy, 1'b0);
    check("abort.set_D", set_D, 1'b0);
    check("abort.miss_done", miss_done, 1'b0);
    reset = 1'b0; rf_done = 1'b0;
    step();
    check("abort.miss_ready", miss_ready, 1'b1);
    check("abort.set_D_after", set_D, 1'b0);
    do_miss(IDX_D, 1'b0, 1'b0, "after_abort");

    // Spurious done pulses in IDLE and CHECK
    wb_done = 1'b1; rf_done = 1'b1;
    step();
    wb_done = 1'b0; rf_done = 1'b0;
    check("spur.idle_busy", busy, 1'b0);
    check("spur.idle_ready", miss_ready, 1'b1);
    miss_valid = 1'b1; miss_index = IDX_E;
    step();
    miss_valid = 1'b0;
    step();
    wb_done = 1'b1; rf_done = 1'b1;
    step();
    wb_done = 1'b0; rf_done = 1'b0;
    check("spur.rf_valid", rf_valid, 1'b1);
    check("spur.wb_valid", wb_valid, 1'b0);
    step();
    step();
    check("spur.rfwait_hold", set_D, 1'b0);
    check("spur.rfwait_busy", busy, 1'b1);
    rf_done = 1'b1;
    step();
    rf_done = 1'b0;
    check("spur.set_D", set_D, 1'b1);
    check("spur.addra", addra, IDX_E);
    step();
    check("miss_done.count", n_miss_done, 7);

`ifdef DCACHE_FLUSH_EN
    // Flush sweep with sets 0, 3, 7 dirty
    do_miss(IW'(0), 1'b1, 1'b0, "fl_set0");
    do_miss(IW'(3), 1'b1, 1'b0, "fl_set3");
    do_miss(IW'(7), 1'b1, 1'b0, "fl_set7");
    flush_req = 1'b1; miss_valid = 1'b1; miss_index = IW'(2);
    step();
    flush_req = 1'b0; miss_valid = 1'b0;
    check("fl.miss_ready", miss_ready, 1'b0);
    check("fl.busy", busy, 1'b1);
    check("fl.addrb", addrb, '0);
    exp_clr = 0; fl_cycles = 0; prev_wb = 1'b0; done_seen = 1'b0;
    for (int i = 0; i < 200 && !done_seen; i++) begin
      wb_done = prev_wb;
      prev_wb = wb_valid;
      if (wb_valid) wb_log.push_back(wb_index);
      if (set_D) begin
        check("fl.clear_addr", addra, exp_clr);
        check("fl.clear_data", wdirt, 1'b0);
        exp_clr++;
      end
      if (flush_done) begin
        done_seen = 1'b1;
        fl_cycles = i + 1;
      end
      step();
    end
    wb_done = 1'b0;
    check("fl.done_seen", done_seen, 1'b1);
    check("fl.cycles", fl_cycles, 30);
    check("fl.clears", exp_clr, 8);
    check("fl.wb_count", wb_log.size(), 3);
    if (wb_log.size() == 3) begin
      check("fl.wb0", wb_log[0], IW'(0));
      check("fl.wb1", wb_log[1], IW'(3));
      check("fl.wb2", wb_log[2], IW'(7));
    end
    check("fl.flush_done_count", n_flush_done, 1);
    check("fl.idle", busy, 1'b0);
    check("fl.ready", miss_ready, 1'b1);
    all_clear = 1'b1;
    for (int i = 0; i < G; i++) if (mem[i] !== 1'b0) all_clear = 1'b0;
    check("fl.all_clear", all_clear, 1'b1);
    do_miss(IW'(3), 1'b0, 1'b0, "post_flush");
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
